// File: rtl/sap_pkg.sv
// Shared constants and history-FIFO operation decode for the SAP bus capture slice.
package sap_pkg;

  localparam int SAP_BUS_W      = 8;
  localparam int SAP_HIST_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_IDLE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_SWAP = 3'd3,
    OP_DROP = 3'd4
  } fifo_op_e;

  // SWAP and DROP move both pointers; DROP is the full-without-pop case that loses data.
  function automatic fifo_op_e fifo_op(input logic push, input logic pop_ok, input logic full);
    fifo_op_e op;
    op = OP_IDLE;
    if (push && pop_ok) begin
      op = OP_SWAP;
    end else if (push && full) begin
      op = OP_DROP;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop_ok) begin
      op = OP_POP;
    end else begin
      op = OP_IDLE;
    end
    return op;
  endfunction

endpackage

// File: rtl/sap_capture_fifo.sv
// Circular history buffer that overwrites its oldest entry when pushed while full.
import sap_pkg::*;

module sap_capture_fifo #(
  parameter int WIDTH = SAP_BUS_W,
  parameter int DEPTH = SAP_HIST_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_s, empty_s, full_s;
  fifo_op_e         op_s;

  assign empty_s = (cnt_q == '0);
  assign full_s  = (cnt_q == CNT_W'(DEPTH));
  assign op_s    = fifo_op(push_i, pop_i & ~empty_s, full_s);

  // Pointer and count next-state; clear overrides any push or pop.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    we_s   = 1'b0;
    drop_o = 1'b0;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      case (op_s)
        OP_PUSH: begin
          we_s  = 1'b1;
          wr_d  = wr_q + PTR_W'(1'b1);
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
        OP_POP: begin
          rd_d  = rd_q + PTR_W'(1'b1);
          cnt_d = cnt_q - CNT_W'(1'b1);
        end
        OP_SWAP: begin
          we_s = 1'b1;
          wr_d = wr_q + PTR_W'(1'b1);
          rd_d = rd_q + PTR_W'(1'b1);
        end
        OP_DROP: begin
          we_s   = 1'b1;
          wr_d   = wr_q + PTR_W'(1'b1);
          rd_d   = rd_q + PTR_W'(1'b1);
          drop_o = 1'b1;
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are masked by empty after reset, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = empty_s ? '0 : mem_q[rd_q];
  assign count_o   = cnt_q;
  assign empty_o   = empty_s;
  assign full_o    = full_s;

endmodule

// File: rtl/sap_bus_capture.sv
// SAP W-bus reader: OUT register, capture history FIFO and sticky fault/overrun flags.
import sap_pkg::*;

module sap_bus_capture #(
  parameter int WIDTH = SAP_BUS_W,
  parameter int DEPTH = SAP_HIST_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       w_bus,
  input  logic                   bus_oe,
  input  logic                   load,
  input  logic                   pop,
  input  logic                   clear,
  output logic [WIDTH-1:0]       out_reg,
  output logic [WIDTH-1:0]       hist_data,
  output logic [$clog2(DEPTH):0] hist_count,
  output logic                   empty,
  output logic                   full,
  output logic                   overrun,
  output logic                   bus_fault
);

  logic [WIDTH-1:0] out_reg_q, out_reg_d;
  logic             overrun_q, overrun_d;
  logic             fault_q, fault_d;
  logic             cap_s, float_s, drop_s;

  // Only a driven bus is a valid capture; a strobe on a floating bus is a fault.
  assign cap_s   = load & bus_oe;
  assign float_s = load & ~bus_oe;

  sap_capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clear),
    .push_i    (cap_s),
    .wr_data_i (w_bus),
    .pop_i     (pop),
    .rd_data_o (hist_data),
    .count_o   (hist_count),
    .empty_o   (empty),
    .full_o    (full),
    .drop_o    (drop_s)
  );

  // Clear wipes the sticky flags and blocks capture but keeps the OUT register.
  always_comb begin
    out_reg_d = out_reg_q;
    overrun_d = overrun_q;
    fault_d   = fault_q;
    if (clear) begin
      overrun_d = 1'b0;
      fault_d   = 1'b0;
    end else begin
      if (cap_s) begin
        out_reg_d = w_bus;
      end else begin
        out_reg_d = out_reg_q;
      end
      if (drop_s) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
      if (float_s) begin
        fault_d = 1'b1;
      end else begin
        fault_d = fault_q;
      end
    end
  end

  // OUT register and sticky flag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg_q <= '0;
      overrun_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      out_reg_q <= out_reg_d;
      overrun_q <= overrun_d;
      fault_q   <= fault_d;
    end
  end

  assign out_reg   = out_reg_q;
  assign overrun   = overrun_q;
  assign bus_fault = fault_q;

endmodule

// File: tb/tb_sap_bus_capture.sv
// Directed and random checks of sap_bus_capture against a queue-based history model.
import sap_pkg::*;

module tb_sap_bus_capture;

  localparam int W  = SAP_BUS_W;
  localparam int D  = SAP_HIST_DEPTH;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset, bus_oe, load, pop, clear;
  logic [W-1:0]  w_bus;
  logic [W-1:0]  out_reg, hist_data;
  logic [CW-1:0] hist_count;
  logic          empty, full, overrun, bus_fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_out;
  logic         m_ovr, m_flt;

  sap_bus_capture dut (
    .clk        (clk),
    .reset      (reset),
    .w_bus      (w_bus),
    .bus_oe     (bus_oe),
    .load       (load),
    .pop        (pop),
    .clear      (clear),
    .out_reg    (out_reg),
    .hist_data  (hist_data),
    .hist_count (hist_count),
    .empty      (empty),
    .full       (full),
    .overrun    (overrun),
    .bus_fault  (bus_fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = '0;
    m_ovr = 1'b0;
    m_flt = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic oe, input logic pp, input logic cl,
                            input logic [W-1:0] wb);
    if (cl) begin
      mq.delete();
      m_ovr = 1'b0;
      m_flt = 1'b0;
    end else begin
      if (ld && !oe) m_flt = 1'b1;
      if (pp && mq.size() > 0) void'(mq.pop_front());
      if (ld && oe) begin
        m_out = wb;
        if (mq.size() == D) begin
          void'(mq.pop_front());
          m_ovr = 1'b1;
        end
        mq.push_back(wb);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] eh;
    eh = (mq.size() != 0) ? mq[0] : '0;
    check_val({tag, ".out_reg"},    32'(out_reg),    32'(m_out));
    check_val({tag, ".hist_data"},  32'(hist_data),  32'(eh));
    check_val({tag, ".hist_count"}, 32'(hist_count), 32'(mq.size()));
    check_val({tag, ".empty"},      32'(empty),      32'(mq.size() == 0));
    check_val({tag, ".full"},       32'(full),       32'(mq.size() == D));
    check_val({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
    check_val({tag, ".bus_fault"},  32'(bus_fault),  32'(m_flt));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare.
  task automatic step(input string tag, input logic ld, input logic oe, input logic pp,
                      input logic cl, input logic [W-1:0] wb);
    load = ld; bus_oe = oe; pop = pp; clear = cl; w_bus = wb;
    @(posedge clk);
    model_edge(ld, oe, pp, cl, wb);
    @(negedge clk);
    check_all(tag);
    load = 1'b0; bus_oe = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  task automatic cap(input string tag, input logic [W-1:0] wb);
    step(tag, 1'b1, 1'b1, 1'b0, 1'b0, wb);
  endtask

  // Reset raised between edges must take effect without a clock edge.
  task automatic reset_mid(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    check_val({tag, ".empty_now"}, 32'(empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1; bus_oe = 1'b0; load = 1'b0; pop = 1'b0; clear = 1'b0; w_bus = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all("por");

    cap("t2", 8'h42);
    check_val("t2.out42", 32'(out_reg), 32'h42);
    check_val("t2.hist42", 32'(hist_data), 32'h42);
    check_val("t2.cnt1", 32'(hist_count), 32'd1);

    cap("t2b", 8'h99);
    reset_mid("t1");

    for (int i = 0; i < 4; i++) cap("t3.fill", vals[i]);
    check_val("t3.full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_val("t3.order", 32'(hist_data), 32'(vals[i]));
      step("t3.pop", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    end
    check_val("t3.empty", 32'(empty), 32'd1);
    check_val("t3.hist0", 32'(hist_data), 32'd0);

    for (int i = 0; i < 4; i++) cap("t4.fill", vals[i]);
    cap("t4.ovr", 8'h55);
    check_val("t4.cnt4", 32'(hist_count), 32'd4);
    check_val("t4.ovr1", 32'(overrun), 32'd1);
    check_val("t4.hist22", 32'(hist_data), 32'h22);
    step("t4.clr", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check_val("t4.ovr0", 32'(overrun), 32'd0);
    check_val("t4.empty", 32'(empty), 32'd1);
    check_val("t4.out55", 32'(out_reg), 32'h55);

    step("t5", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    check_val("t5.out55", 32'(out_reg), 32'h55);
    check_val("t5.cnt0", 32'(hist_count), 32'd0);
    check_val("t5.fault", 32'(bus_fault), 32'd1);

    step("t6.clr", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) cap("t6.fill", vals[i]);
    step("t6.swap", 1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
    check_val("t6.cnt4", 32'(hist_count), 32'd4);
    check_val("t6.ovr0", 32'(overrun), 32'd0);
    for (int i = 0; i < 3; i++) step("t6.pop", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_val("t6.newest", 32'(hist_data), 32'h66);
    step("t6.clr2", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step("t6.popempty", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_val("t6.cnt0", 32'(hist_count), 32'd0);
    check_val("t6.noflag", 32'(overrun), 32'd0);

    for (int n = 0; n < 600; n++) begin
      step("rnd",
           1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 85),
           1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 31) == 0),
           W'($urandom));
      if (n % 97 == 96) reset_mid("rnd.reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
